// File: rtl/uart_pkg.sv
// Shared UART definitions: parity_type encodings and the transmitter FSM
// state encoding, used by the serializer and the upstream parity generator.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // 2'b11 is treated like PAR_NONE: no parity bit on the line.
  function automatic logic has_parity(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit; clear restarts the period when the serializer changes state.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || bit_end) cnt <= '0;
    else                           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start, 8 data bits LSB first, optional parity bit
// supplied by the upstream parity generator, then STOP_BITS stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] din,
  input  logic [1:0] parity_type,
  input  logic       parity_bit,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] din_q;
  logic [1:0] ptype_q;
  logic       par_q;
  logic       clear, bit_end, tx_out_n;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .bit_end (bit_end)
  );

  // idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (tx_start) state_n = START;
      START:   if (bit_end) state_n = DATA;
      DATA:    if (bit_end && idx == 3'd7)
                 state_n = has_parity(ptype_q) ? PARITY : STOP;
      PARITY:  if (bit_end) state_n = STOP;
      STOP:    if (bit_end && idx == 3'(STOP_BITS - 1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    clear = (state_n != state);
    idx_n = idx;
    if (clear)        idx_n = 3'd0;
    else if (bit_end) idx_n = idx + 3'd1;

    // Line level is computed for the upcoming cycle so tx_out is a flop.
    tx_out_n = 1'b1;
    case (state_n)
      START:   tx_out_n = 1'b0;
      DATA:    tx_out_n = din_q[idx_n];
      PARITY:  tx_out_n = par_q;
      default: tx_out_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 3'd0;
      tx_out  <= 1'b1;
      tx_done <= 1'b0;
      din_q   <= 8'h00;
      ptype_q <= PAR_NONE;
      par_q   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      tx_out  <= tx_out_n;
      tx_done <= (state == STOP) && (state_n == IDLE);
      if (state == IDLE && tx_start) begin
        din_q   <= din;
        ptype_q <= parity_type;
        par_q   <= parity_bit;
      end
    end
  end

  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer (CLKS_PER_BIT=4): a scoreboard of modelled
// frame waveforms checked by a line monitor, plus a STOP_BITS=2 instance.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  typedef struct {
    logic [63:0] wave;
    int          len;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic [1:0] pt;
    int         len;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic       parity_bit = 1'b0;
  logic       tx_out, tx_busy, tx_done;

  logic       start2 = 1'b0;
  logic [7:0] din2 = 8'h00;
  logic [1:0] pt2 = 2'b00;
  logic       pb2 = 1'b0;
  logic       out2, busy2, done2;

  int total = 0;
  int bad = 0;

  exp_t        exp_q[$];
  int          mon_len = 0;
  logic [63:0] mon_wave = '1;
  logic        prev_busy = 1'b0;
  int          done_cnt = 0;
  int          last_len = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .din(din),
    .parity_type(parity_type), .parity_bit(parity_bit),
    .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tx_start(start2), .din(din2),
    .parity_type(pt2), .parity_bit(pb2),
    .tx_out(out2), .tx_busy(busy2), .tx_done(done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Parity generator model.
  function automatic logic pgen(input logic [7:0] d, input logic [1:0] pt);
    case (pt)
      2'b01:   return ~^d;
      2'b10:   return ^d;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t build(input logic [7:0] d, input logic [1:0] pt,
                                 input logic pb, input int stops);
    exp_t        e;
    logic [11:0] b;
    int          nb;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    nb = 9;
    if (pt == 2'b01 || pt == 2'b10) begin
      b[9] = pb;
      nb = 10;
    end
    for (int s = 0; s < stops; s++) b[nb+s] = 1'b1;
    nb += stops;
    e.wave = '1;
    for (int i = 0; i < nb; i++)
      for (int k = 0; k < CPB; k++) e.wave[i*CPB+k] = b[i];
    e.len = nb * CPB;
    return e;
  endfunction

  // Line monitor: captures each frame while busy, checks it on busy fall.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      chk("rst_out", tx_out, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      if (mon_len > 0 && exp_q.size() > 0) e = exp_q.pop_front();
      mon_len = 0;
      mon_wave = '1;
      prev_busy = 1'b0;
    end else begin
      if (tx_busy) begin
        if (mon_len < 64) mon_wave[mon_len] = tx_out;
        mon_len++;
      end
      if (prev_busy && !tx_busy) begin
        chk("done_pulse", tx_done, 1);
        chk("idle_out", tx_out, 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got len %0d want none", mon_len);
        end else begin
          e = exp_q.pop_front();
          chk("frame_len", mon_len, e.len);
          chk("frame_bits", mon_wave, e.wave);
        end
        last_len = mon_len;
        done_cnt++;
        mon_len = 0;
        mon_wave = '1;
      end else begin
        chk("no_done", tx_done, 0);
      end
      prev_busy = tx_busy;
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] pt);
    @(negedge clk);
    din = d;
    parity_type = pt;
    parity_bit = pgen(d, pt);
    tx_start = 1'b1;
    exp_q.push_back(build(d, pt, parity_bit, 1));
    @(posedge clk);
    #1;
    chk("lat_busy", tx_busy, 1);
    chk("lat_out", tx_out, 0);
    @(negedge clk);
    tx_start = 1'b0;
    din = 8'($urandom);
    parity_type = 2'($urandom);
    parity_bit = 1'($urandom);
  endtask

  task automatic wait_frames(input int n, input string name);
    int start_cnt;
    start_cnt = done_cnt;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done_cnt >= start_cnt + n) return;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got %0d frames want %0d", name, done_cnt - start_cnt, n);
  endtask

  initial begin
    vec_t        tbl[7];
    exp_t        e2;
    logic [63:0] w2;
    int          n, cnt0;

    tbl[0] = '{8'h01, 2'b01, 44};
    tbl[1] = '{8'h03, 2'b00, 40};
    tbl[2] = '{8'h03, 2'b11, 40};
    tbl[3] = '{8'hA5, 2'b10, 44};
    tbl[4] = '{8'hFF, 2'b01, 44};
    tbl[5] = '{8'h00, 2'b10, 44};
    tbl[6] = '{8'h80, 2'b00, 40};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].din, tbl[i].pt);
      wait_frames(1, "vec");
      chk("vec_len", last_len, tbl[i].len);
    end

    // Held tx_start: second frame accepted in the tx_done cycle.
    @(negedge clk);
    din = 8'hA5;
    parity_type = 2'b10;
    parity_bit = pgen(8'hA5, 2'b10);
    tx_start = 1'b1;
    exp_q.push_back(build(8'hA5, 2'b10, parity_bit, 1));
    exp_q.push_back(build(8'hA5, 2'b10, parity_bit, 1));
    wait_frames(1, "b2b_first");
    chk("b2b_done", tx_done, 1);
    chk("b2b_idle_busy", tx_busy, 0);
    @(posedge clk);
    #1;
    chk("b2b_restart_busy", tx_busy, 1);
    chk("b2b_restart_out", tx_out, 0);
    @(negedge clk);
    tx_start = 1'b0;
    wait_frames(1, "b2b_second");
    chk("b2b_len", last_len, 44);

    // tx_start mid-frame is ignored and the latched byte is kept.
    send(8'h5A, 2'b01);
    repeat (8) @(negedge clk);
    din = 8'h00;
    parity_type = 2'b00;
    parity_bit = 1'b1;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    cnt0 = done_cnt;
    wait_frames(1, "ignore");
    repeat (60) @(negedge clk);
    chk("ignore_one_frame", done_cnt - cnt0, 1);
    chk("ignore_idle", tx_busy, 0);

    // Reset during DATA bit 3 aborts the frame.
    send(8'hC3, 2'b10);
    repeat (16) @(negedge clk);
    reset = 1'b1;
    cnt0 = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_cnt - cnt0, 0);
    chk("abort_idle", tx_busy, 0);
    chk("abort_q_drained", exp_q.size(), 0);
    send(8'h3C, 2'b01);
    wait_frames(1, "after_abort");
    chk("after_abort_len", last_len, 44);

    // Reset wins over tx_start in the same cycle.
    @(negedge clk);
    reset = 1'b1;
    tx_start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tx_start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_prio_busy", tx_busy, 0);
    chk("rst_prio_out", tx_out, 1);

    // Two stop bits on the second instance.
    @(negedge clk);
    din2 = 8'hFF;
    pt2 = 2'b01;
    pb2 = pgen(8'hFF, 2'b01);
    start2 = 1'b1;
    e2 = build(8'hFF, 2'b01, pb2, 2);
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n = 0;
    w2 = '1;
    for (int c = 0; c < 100; c++) begin
      if (!busy2) break;
      w2[n] = out2;
      n++;
      @(posedge clk);
      #1;
    end
    chk("sb2_len", n, 48);
    chk("sb2_bits", w2, e2.wave);
    chk("sb2_stop_high", w2[47:40], 8'hFF);
    chk("sb2_parity", w2[39:36], 4'hF);
    chk("sb2_done", done2, 1);

    repeat (5) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
